// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction fetch stage.
// Owns the PC, issues word reads to instruction memory over a valid/ready
// handshake, buffers returned words in a small FIFO and presents one
// instruction per cycle on registered outputs (instr / instr_pc / instr_valid).
// Optional feature: define HAZARD_INTERLOCK_EN to hold the FIFO head and issue
// bubbles while the execute stage writes a register the head instruction reads.
module pipeline_fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] NOP_INSTR  = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        execute_is_dependent,
    input  logic [15:0] execute_instr,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid
);

    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic             rst_q_r;
    logic [15:0]      pc_r;
    logic [15:0]      fifo_pc_r    [FIFO_DEPTH];
    logic [15:0]      fifo_instr_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      instr_r;
    logic [15:0]      instr_pc_r;
    logic             instr_valid_r;

    logic             not_empty_s;
    logic             full_s;
    logic             req_s;
    logic             push_s;
    logic             pop_s;
    logic             hazard_s;
    logic [15:0]      head_pc_s;
    logic [15:0]      head_instr_s;

    assign not_empty_s  = (count_r != {CNT_W{1'b0}});
    assign full_s       = (count_r == DEPTH_C);
    assign head_pc_s    = fifo_pc_r[rd_ptr_r];
    assign head_instr_s = fifo_instr_r[rd_ptr_r];

`ifdef HAZARD_INTERLOCK_EN
    // Only the destination field of the execute-stage instruction matters.
    logic unused_exec_s;
    assign unused_exec_s = ^execute_instr[15:3];

    // RAW interlock: head reads a register the execute stage is about to write.
    always_comb begin
        hazard_s = 1'b0;
        if (not_empty_s && execute_is_dependent &&
            ((execute_instr[2:0] == head_instr_s[8:6]) ||
             (execute_instr[2:0] == head_instr_s[5:3]))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end
`else
    // Without the interlock, software schedules around dependencies.
    logic unused_exec_s;
    assign unused_exec_s = ^{execute_is_dependent, execute_instr};
    assign hazard_s      = 1'b0;
`endif

    // Handshake and FIFO control: no request while full, in reset, or redirecting.
    always_comb begin
        req_s  = 1'b0;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!rst_q_r && !full_s && !redirect_valid) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        push_s = req_s && imem_ready;
        pop_s  = !redirect_valid && !stall && not_empty_s && !hazard_s;
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

    // Delayed reset keeps the first request one cycle clear of reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q_r <= 1'b1;
        end else begin
            rst_q_r <= 1'b0;
        end
    end

    // Program counter: redirect reloads, each accepted read advances (wraps at 16 bits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc;
        end else if (push_s) begin
            pc_r <= pc_r + 16'd1;
        end else begin
            pc_r <= pc_r;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: each accepted word is stored with the PC it was fetched from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= 16'h0000;
                fifo_instr_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= pc_r;
            fifo_instr_r[wr_ptr_r] <= imem_rdata;
        end else begin
            fifo_pc_r    <= fifo_pc_r;
            fifo_instr_r <= fifo_instr_r;
        end
    end

    // Output register: redirect bubbles, stall holds, otherwise pop head or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= 16'h0000;
            instr_valid_r <= 1'b0;
        end else if (redirect_valid) begin
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= instr_pc_r;
            instr_valid_r <= 1'b0;
        end else if (stall) begin
            instr_r       <= instr_r;
            instr_pc_r    <= instr_pc_r;
            instr_valid_r <= instr_valid_r;
        end else if (pop_s) begin
            instr_r       <= head_instr_s;
            instr_pc_r    <= head_pc_s;
            instr_valid_r <= 1'b1;
        end else begin
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= instr_pc_r;
            instr_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: scoreboard bench for pipeline_fetch.
// Memory model returns addr ^ 16'hA5A5. A monitor pushes the expected
// {pc, word} on every handshake and pops it when instr_valid shows a new word.
module tb_pipeline_fetch;

    localparam logic [15:0] NOP = 16'hF000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        execute_is_dependent = 1'b0;
    logic [15:0] execute_instr = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    // Second instance with RESET_PC at the top of the address space.
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_rdata;
    logic        w_ready = 1'b1;
    logic        w_zero = 1'b0;
    logic [15:0] w_zero16 = 16'h0000;
    logic [15:0] w_instr;
    logic [15:0] w_instr_pc;
    logic        w_valid;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t last_exp = '0;
    exp_t mon_e;
    logic [15:0] model_pc = 16'h0000;
    logic        prev_stall = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 16'hA5A5;
    assign w_rdata    = w_addr ^ 16'hA5A5;

    pipeline_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .execute_is_dependent(execute_is_dependent), .execute_instr(execute_instr),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    pipeline_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_ready), .imem_rdata(w_rdata),
        .stall(w_zero), .redirect_valid(w_zero), .redirect_pc(w_zero16),
        .execute_is_dependent(w_zero), .execute_instr(w_zero16),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid)
    );

    // Scoreboard monitor for the main instance, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                model_pc   = 16'h0000;
                prev_stall = 1'b0;
            end else begin
                if (instr_valid) begin
                    n_vec++;
                    if (prev_stall) begin
                        if (instr !== last_exp.ins || instr_pc !== last_exp.pc) begin
                            n_err++;
                            $display("FAIL hold_output: got instr=%h pc=%h, expected instr=%h pc=%h",
                                     instr, instr_pc, last_exp.ins, last_exp.pc);
                        end
                    end else if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_instr: got instr=%h pc=%h, expected no valid instr",
                                 instr, instr_pc);
                    end else begin
                        last_exp = sb.pop_front();
                        if (instr !== last_exp.ins || instr_pc !== last_exp.pc) begin
                            n_err++;
                            $display("FAIL issue_order: got instr=%h pc=%h, expected instr=%h pc=%h",
                                     instr, instr_pc, last_exp.ins, last_exp.pc);
                        end
                    end
                end else begin
                    n_vec++;
                    if (instr !== NOP) begin
                        n_err++;
                        $display("FAIL bubble_encoding: got instr=%h, expected %h", instr, NOP);
                    end
                end
                if (imem_req && imem_ready) begin
                    n_vec++;
                    if (imem_addr !== model_pc) begin
                        n_err++;
                        $display("FAIL fetch_addr: got %h, expected %h", imem_addr, model_pc);
                    end
                    mon_e.pc  = model_pc;
                    mon_e.ins = model_pc ^ 16'hA5A5;
                    sb.push_back(mon_e);
                    model_pc  = model_pc + 16'd1;
                end
                if (redirect_valid) begin
                    n_vec++;
                    if (imem_req !== 1'b0) begin
                        n_err++;
                        $display("FAIL redirect_req: got imem_req=%b, expected 0", imem_req);
                    end
                    sb.delete();
                    model_pc = redirect_pc;
                end
                prev_stall = stall;
            end
        end
    end

    task automatic wait_drive;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) wait_drive();
        n_vec++;
        if (imem_req !== 1'b0 || instr !== NOP || instr_pc !== 16'h0000 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got req=%b instr=%h pc=%h valid=%b, expected 0 %h 0000 0",
                     imem_req, instr, instr_pc, instr_valid, NOP);
        end
        rst = 1'b0;
        wait_neg();
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL req_after_release: got %b, expected 0", imem_req);
        end
        wait_neg();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL first_req: got req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream;
        wait_drive();
        imem_ready = 1'b1;
        wait_neg();
        wait_neg();
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got valid=%b, expected 0", instr_valid);
        end
        wait_neg();
        n_vec++;
        if (instr !== 16'hA5A5 || instr_pc !== 16'h0000 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL first_instr: got instr=%h pc=%h valid=%b, expected a5a5 0000 1",
                     instr, instr_pc, instr_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            wait_neg();
            n_vec++;
            if (instr_pc !== 16'(k) || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stream_pc: got pc=%h valid=%b, expected %h 1", instr_pc, instr_valid, 16'(k));
            end
        end
    endtask

    task automatic test_ready_gap;
        logic [15:0] held_addr;
        wait_drive();
        imem_ready = 1'b0;
        wait_neg();
        held_addr = model_pc;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_neg();
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                n_err++;
                $display("FAIL ready_gap_hold: got req=%b addr=%h, expected 1 %h", imem_req, imem_addr, held_addr);
            end
        end
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ready_gap_bubble: got valid=%b, expected 0", instr_valid);
        end
        wait_drive();
        imem_ready = 1'b1;
        repeat (5) wait_neg();
    endtask

    task automatic test_stall;
        logic [15:0] held_pc;
        wait_drive();
        stall = 1'b1;
        wait_neg();
        held_pc = last_exp.pc;
        for (int k = 0; k < 3; k++) begin
            wait_neg();
            n_vec++;
            if (imem_req !== 1'b0 || instr_pc !== held_pc || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_full: got req=%b pc=%h valid=%b, expected 0 %h 1",
                         imem_req, instr_pc, instr_valid, held_pc);
            end
        end
        wait_drive();
        stall = 1'b0;
        wait_neg();
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL full_with_pop: got req=%b, expected 0", imem_req);
        end
        for (int k = 1; k <= 2; k++) begin
            wait_neg();
            n_vec++;
            if (instr_pc !== held_pc + 16'(k) || instr_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_release: got pc=%h valid=%b, expected %h 1",
                         instr_pc, instr_valid, held_pc + 16'(k));
            end
        end
    endtask

    task automatic test_redirect;
        wait_drive();
        stall = 1'b1;
        repeat (3) wait_neg();
        wait_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        wait_neg();
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_cycle_req: got %b, expected 0", imem_req);
        end
        wait_drive();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        wait_neg();
        n_vec++;
        if (instr_valid !== 1'b0 || instr !== NOP || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_next: got valid=%b instr=%h addr=%h req=%b, expected 0 %h 0040 1",
                     instr_valid, instr, imem_addr, imem_req, NOP);
        end
        wait_neg();
        wait_neg();
        n_vec++;
        if (instr !== 16'hA5E5 || instr_pc !== 16'h0040 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_target: got instr=%h pc=%h valid=%b, expected a5e5 0040 1",
                     instr, instr_pc, instr_valid);
        end
    endtask

    task automatic test_wrap;
        exp_t        wq[$];
        exp_t        we;
        logic [15:0] wpc;
        logic [15:0] seen[$];
        imem_ready = 1'b0;
        rst        = 1'b1;
        repeat (2) wait_drive();
        rst = 1'b0;
        wpc = 16'hFFFF;
        for (int c = 0; c < 8; c++) begin
            wait_neg();
            if (w_valid) begin
                n_vec++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL wrap_unexpected: got pc=%h, expected no valid instr", w_instr_pc);
                end else begin
                    we = wq.pop_front();
                    seen.push_back(w_instr_pc);
                    if (w_instr !== we.ins || w_instr_pc !== we.pc) begin
                        n_err++;
                        $display("FAIL wrap_issue: got instr=%h pc=%h, expected instr=%h pc=%h",
                                 w_instr, w_instr_pc, we.ins, we.pc);
                    end
                end
            end
            if (w_req && w_ready) begin
                n_vec++;
                if (w_addr !== wpc) begin
                    n_err++;
                    $display("FAIL wrap_addr: got %h, expected %h", w_addr, wpc);
                end
                we.pc  = wpc;
                we.ins = wpc ^ 16'hA5A5;
                wq.push_back(we);
                wpc = wpc + 16'd1;
            end
        end
        n_vec++;
        if (seen.size() < 2) begin
            n_err++;
            $display("FAIL wrap_count: got %0d instrs, expected at least 2", seen.size());
        end else if (seen[0] !== 16'hFFFF || seen[1] !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_pc: got %h,%h, expected ffff,0000", seen[0], seen[1]);
        end
    endtask

`ifdef HAZARD_INTERLOCK_EN
    task automatic test_hazard;
        wait_drive();
        execute_is_dependent = 1'b1;
        execute_instr        = 16'h0002;
        redirect_valid       = 1'b1;
        redirect_pc          = 16'h0100;
        imem_ready           = 1'b1;
        wait_neg();
        wait_drive();
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_neg();
            n_vec++;
            if (instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hazard_bubble: got valid=%b, expected 0", instr_valid);
            end
        end
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_full: got req=%b, expected 0", imem_req);
        end
        wait_drive();
        execute_is_dependent = 1'b0;
        wait_neg();
        wait_neg();
        n_vec++;
        if (instr !== 16'hA4A5 || instr_pc !== 16'h0100 || instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_release: got instr=%h pc=%h valid=%b, expected a4a5 0100 1",
                     instr, instr_pc, instr_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_ready_gap();
        test_stall();
        test_redirect();
        test_wrap();
`ifdef HAZARD_INTERLOCK_EN
        test_hazard();
`endif
        repeat (2) wait_neg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
